// File: rtl/jtag_debug_pkg.sv
// Shared definitions for the JTAG debug command decoder: opcodes, FSM
// encoding and status-bit positions within reg_addr_d.
package jtag_debug_pkg;

    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_READ_MEM  = 3'd1;
    localparam logic [2:0] OP_WRITE_MEM = 3'd2;
    localparam logic [2:0] OP_READ_SEQ  = 3'd3;
    localparam logic [2:0] OP_WRITE_SEQ = 3'd4;
    localparam logic [2:0] OP_BREAK     = 3'd5;
    localparam logic [2:0] OP_RESET     = 3'd6;
    localparam logic [2:0] OP_UART_TX   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4
    } state_t;

    localparam int STAT_BUSY = 0;
    localparam int STAT_RESP = 1;
    localparam int STAT_OVR  = 2;

    // Operations that return a data byte and therefore wait for rsp_valid.
    function automatic logic op_is_read(input logic [2:0] op);
        return (op == OP_READ_MEM) || (op == OP_READ_SEQ);
    endfunction

endpackage

// File: rtl/jtag_debug_shiftreg.sv
// MSB-first address assembler: shifts one byte per strobe and flags the
// final byte of an ADDR_W-bit address.
module jtag_debug_shiftreg #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              shift,
    input  logic [7:0]        byte_in,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] addr_nxt,
    output logic              last
);

    localparam int NBYTES = ADDR_W / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [CNT_W-1:0] cnt;

    // Value the address takes once the byte on byte_in is shifted in; lets
    // the caller capture a complete address on the final strobe's edge.
    assign addr_nxt = (addr << 8) | ADDR_W'(byte_in);
    assign last     = (cnt == CNT_W'(NBYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
            cnt  <= '0;
        end else if (clear) begin
            addr <= '0;
            cnt  <= '0;
        end else if (shift) begin
            addr <= addr_nxt;
            cnt  <= last ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/jtag_debug_decoder.sv
// JTAG debug channel command decoder: assembles multi-byte commands from the
// 8-bit register stream and issues them over a valid/ready port.
module jtag_debug_decoder
    import jtag_debug_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              jtck,
    input  logic              jrstn,
    input  logic              reg_update,
    input  logic [7:0]        reg_q,
    input  logic [2:0]        reg_addr_q,
    output logic [7:0]        reg_d,
    output logic [2:0]        reg_addr_d,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [2:0]        cmd_op,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [7:0]        cmd_data,
    input  logic              rsp_valid,
    input  logic [7:0]        rsp_data
);

    state_t            state, state_nxt;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [7:0]        data_q;
    logic [7:0]        reg_d_q;
    logic              resp_q;
    logic              ovr_q;

    logic              cmd_byte;
    logic              cmd_legal;
    logic [2:0]        opc;
    logic              sr_shift;
    logic              sr_last;
    logic [ADDR_W-1:0] sr_addr;
    logic [ADDR_W-1:0] sr_addr_nxt;
    logic              drop_byte;

    assign cmd_byte  = reg_update && (state == ST_IDLE) && (reg_addr_q == 3'd0);
    assign cmd_legal = cmd_byte && !reg_q[3];
    assign opc       = reg_q[2:0];
    assign sr_shift  = reg_update && (state == ST_ADDR);
    assign drop_byte = reg_update && ((state == ST_ISSUE) || (state == ST_WAIT));

    jtag_debug_shiftreg #(
        .ADDR_W (ADDR_W)
    ) u_shiftreg (
        .clk      (jtck),
        .rst_n    (jrstn),
        .clear    (cmd_legal),
        .shift    (sr_shift),
        .byte_in  (reg_q),
        .addr     (sr_addr),
        .addr_nxt (sr_addr_nxt),
        .last     (sr_last)
    );

    always_ff @(posedge jtck or negedge jrstn) begin
        if (!jrstn) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cmd_legal) begin
                    case (opc)
                        OP_NOP:                     state_nxt = ST_IDLE;
                        OP_READ_MEM, OP_WRITE_MEM:  state_nxt = ST_ADDR;
                        OP_WRITE_SEQ, OP_UART_TX:   state_nxt = ST_DATA;
                        default:                    state_nxt = ST_ISSUE;
                    endcase
                end
            end
            ST_ADDR: begin
                if (reg_update && sr_last)
                    state_nxt = (op_q == OP_WRITE_MEM) ? ST_DATA : ST_ISSUE;
            end
            ST_DATA: begin
                if (reg_update) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (cmd_ready) state_nxt = op_is_read(op_q) ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
                if (rsp_valid) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The pointer doubles as the issued address: it is updated on the edge
    // that enters ISSUE (or DATA) and held untouched while ISSUE waits.
    always_ff @(posedge jtck or negedge jrstn) begin
        if (!jrstn) begin
            op_q    <= OP_NOP;
            ptr_q   <= '0;
            data_q  <= '0;
            reg_d_q <= '0;
            resp_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (cmd_legal) begin
                resp_q <= 1'b0;
                if (opc == OP_NOP) ovr_q <= 1'b0;
                else               op_q  <= opc;
                if (opc == OP_READ_SEQ) ptr_q <= ptr_q + ADDR_W'(1);
            end
            if (cmd_byte && !cmd_legal) ovr_q <= 1'b1;
            if (drop_byte)              ovr_q <= 1'b1;
            if (sr_shift && sr_last)    ptr_q <= sr_addr_nxt;
            if (reg_update && (state == ST_DATA)) begin
                data_q <= reg_q;
                if (op_q == OP_WRITE_SEQ) ptr_q <= ptr_q + ADDR_W'(1);
            end
            if ((state == ST_WAIT) && rsp_valid) begin
                reg_d_q <= rsp_data;
                resp_q  <= 1'b1;
            end
        end
    end

    assign cmd_valid  = (state == ST_ISSUE);
    assign cmd_op     = op_q;
    assign cmd_addr   = ptr_q;
    assign cmd_data   = data_q;
    assign reg_d      = reg_d_q;

    always_comb begin
        reg_addr_d            = '0;
        reg_addr_d[STAT_BUSY] = (state != ST_IDLE);
        reg_addr_d[STAT_RESP] = resp_q;
        reg_addr_d[STAT_OVR]  = ovr_q;
    end

endmodule

// File: tb/tb_jtag_debug_decoder.sv
// Scoreboard bench for jtag_debug_decoder: expected commands are queued as
// bytes are sent and checked when the DUT completes a handshake.
module tb_jtag_debug_decoder;
    import jtag_debug_pkg::*;

    localparam int ADDR_W = 32;

    logic              jtck = 1'b0;
    logic              jrstn;
    logic              reg_update;
    logic [7:0]        reg_q;
    logic [2:0]        reg_addr_q;
    logic [7:0]        reg_d;
    logic [2:0]        reg_addr_d;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        cmd_data;
    logic              rsp_valid;
    logic [7:0]        rsp_data;

    typedef struct packed {
        logic [2:0]        op;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } cmd_t;

    cmd_t exp_q[$];
    cmd_t mon_e;
    int   n_vec  = 0;
    int   n_miss = 0;

    jtag_debug_decoder #(.ADDR_W(ADDR_W)) dut (
        .jtck       (jtck),
        .jrstn      (jrstn),
        .reg_update (reg_update),
        .reg_q      (reg_q),
        .reg_addr_q (reg_addr_q),
        .reg_d      (reg_d),
        .reg_addr_d (reg_addr_d),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data)
    );

    always #5 jtck = ~jtck;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge jtck) begin
        if (jrstn && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_cmd", 64'(cmd_valid), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("cmd_op", 64'(cmd_op), 64'(mon_e.op));
                check_eq("cmd_addr", 64'(cmd_addr), 64'(mon_e.addr));
                if (mon_e.op == OP_WRITE_MEM || mon_e.op == OP_WRITE_SEQ || mon_e.op == OP_UART_TX)
                    check_eq("cmd_data", 64'(cmd_data), 64'(mon_e.data));
            end
        end
    end

    task automatic send_byte(input logic [2:0] a, input logic [7:0] b);
        @(posedge jtck); #1;
        reg_update = 1'b1;
        reg_addr_q = a;
        reg_q      = b;
        @(posedge jtck); #1;
        reg_update = 1'b0;
        reg_addr_q = 3'd5;
        reg_q      = 8'hEE;
    endtask

    task automatic push_cmd(input logic [2:0] op, input logic [ADDR_W-1:0] addr, input logic [7:0] data);
        cmd_t c;
        c.op   = op;
        c.addr = addr;
        c.data = data;
        exp_q.push_back(c);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge jtck);
        while (reg_addr_d[STAT_BUSY] && n < 50) begin
            @(negedge jtck);
            n++;
        end
        check_eq(tag, 64'(reg_addr_d[STAT_BUSY]), 64'd0);
    endtask

    task automatic pulse_rsp(input logic [7:0] d);
        @(posedge jtck); #1;
        rsp_valid = 1'b1;
        rsp_data  = d;
        @(posedge jtck); #1;
        rsp_valid = 1'b0;
        rsp_data  = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rd_bytes[4];
        jrstn      = 1'b0;
        reg_update = 1'b0;
        reg_q      = 8'h00;
        reg_addr_q = 3'd0;
        cmd_ready  = 1'b1;
        rsp_valid  = 1'b0;
        rsp_data   = 8'h00;
        repeat (3) @(negedge jtck);
        check_eq("rst_reg_d", 64'(reg_d), 64'd0);
        check_eq("rst_status", 64'(reg_addr_d), 64'd0);
        check_eq("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        check_eq("rst_cmd_fields", {cmd_op, cmd_addr, cmd_data}, 64'd0);
        @(posedge jtck); #1;
        jrstn = 1'b1;

        // READ_MEM 0x12345678, zero-wait ready, then read data 0xA5
        rd_bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
        push_cmd(OP_READ_MEM, 32'h12345678, 8'h00);
        send_byte(3'd0, 8'h01);
        foreach (rd_bytes[i]) send_byte(3'd0, rd_bytes[i]);
        @(negedge jtck);
        check_eq("rd_valid_hi", 64'(cmd_valid), 64'd1);
        @(negedge jtck);
        check_eq("rd_valid_one_cycle", 64'(cmd_valid), 64'd0);
        check_eq("rd_wait_status", 64'(reg_addr_d), 64'b001);
        pulse_rsp(8'hA5);
        @(negedge jtck);
        check_eq("rd_reg_d", 64'(reg_d), 64'hA5);
        check_eq("rd_status", 64'(reg_addr_d), 64'b010);

        // WRITE_MEM 0xFFFFFFFF / 0x3C, then WRITE_SEQ wraps to 0
        push_cmd(OP_WRITE_MEM, 32'hFFFFFFFF, 8'h3C);
        send_byte(3'd0, 8'h02);
        repeat (4) send_byte(3'd0, 8'hFF);
        send_byte(3'd0, 8'h3C);
        wait_idle("wr_idle");
        check_eq("wr_resp_cleared", 64'(reg_addr_d), 64'b000);
        push_cmd(OP_WRITE_SEQ, 32'h00000000, 8'h11);
        send_byte(3'd0, 8'h04);
        send_byte(3'd0, 8'h11);
        wait_idle("wseq_idle");

        // UART_TX with ready held low for 5 cycles, stray byte sets overrun
        cmd_ready = 1'b0;
        push_cmd(OP_UART_TX, 32'h00000000, 8'h41);
        send_byte(3'd0, 8'h07);
        send_byte(3'd0, 8'h41);
        for (int i = 0; i < 2; i++) begin
            @(negedge jtck);
            check_eq("uart_hold", {cmd_valid, cmd_op, cmd_addr, cmd_data}, {1'b1, OP_UART_TX, 32'h0, 8'h41});
        end
        send_byte(3'd0, 8'h99);
        for (int i = 0; i < 3; i++) begin
            @(negedge jtck);
            check_eq("uart_hold2", {cmd_valid, cmd_op, cmd_addr, cmd_data}, {1'b1, OP_UART_TX, 32'h0, 8'h41});
        end
        check_eq("uart_overrun", 64'(reg_addr_d), 64'b101);
        @(posedge jtck); #1;
        cmd_ready = 1'b1;
        wait_idle("uart_idle");

        // NOP clears overrun; illegal opcode sets it and issues nothing
        send_byte(3'd0, 8'h00);
        @(negedge jtck);
        check_eq("nop_clear", 64'(reg_addr_d), 64'b000);
        send_byte(3'd0, 8'h0F);
        repeat (3) @(negedge jtck);
        check_eq("illegal_status", 64'(reg_addr_d), 64'b100);
        check_eq("illegal_no_cmd", 64'(cmd_valid), 64'd0);
        send_byte(3'd0, 8'h00);
        @(negedge jtck);
        check_eq("nop_clear2", 64'(reg_addr_d), 64'b000);

        // Reset mid-address, then BREAK from a cleared pointer
        send_byte(3'd0, 8'h01);
        send_byte(3'd0, 8'hAA);
        send_byte(3'd0, 8'hBB);
        @(posedge jtck); #1;
        jrstn = 1'b0;
        #2;
        check_eq("abort_status", 64'(reg_addr_d), 64'd0);
        check_eq("abort_valid", 64'(cmd_valid), 64'd0);
        @(posedge jtck); #1;
        jrstn = 1'b1;
        push_cmd(OP_BREAK, 32'h00000000, 8'h00);
        send_byte(3'd0, 8'h05);
        wait_idle("break_idle");

        // READ_SEQ with rsp_valid in the handshake cycle
        cmd_ready = 1'b0;
        push_cmd(OP_READ_SEQ, 32'h00000001, 8'h00);
        send_byte(3'd0, 8'h03);
        @(posedge jtck); #1;
        cmd_ready = 1'b1;
        rsp_valid = 1'b1;
        rsp_data  = 8'h5A;
        @(posedge jtck); #1;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        repeat (2) @(negedge jtck);
        check_eq("rseq_wait_status", 64'(reg_addr_d), 64'b001);
        check_eq("rseq_reg_d_kept", 64'(reg_d), 64'h00);
        pulse_rsp(8'hC3);
        @(negedge jtck);
        check_eq("rseq_reg_d", 64'(reg_d), 64'hC3);
        check_eq("rseq_status", 64'(reg_addr_d), 64'b010);

        check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/jtag_debug_decoder.md
# jtag_debug_decoder

Command decoder at the CPU end of the 8-bit JTAG debug register channel. It consumes the byte stream the JTAG core delivers on `reg_update`/`reg_q`/`reg_addr_q` and assembles multi-byte debug commands: memory read/write, sequential access, break, reset and UART byte. Each assembled command is issued over a valid/ready port toward the debug bus master. Read results and status are returned to the JTAG core on `reg_d`/`reg_addr_d`. The block runs entirely in the `jtck` domain; the debug bus master owns any clock-domain crossing.

## Interface
Parameters:
- `ADDR_W`, 32: debug address width, a multiple of 8 (assembled from `ADDR_W/8` bytes).

Ports:
- `jtck` in 1: JTAG-derived clock, the only clock.
- `jrstn` in 1: reset, asynchronous, active-low.
- `reg_update` in 1: one-cycle strobe; a new byte is present on `reg_q`/`reg_addr_q`.
- `reg_q` in 8: received byte.
- `reg_addr_q` in 3: register select; meaningful only on a command byte.
- `reg_d` out 8: last read/response byte returned to the JTAG core.
- `reg_addr_d` out 3: status {`overrun`, `resp_valid`, `busy`} (bit 2..0).
- `cmd_valid` out 1: command presented.
- `cmd_ready` in 1: consumer accepts the command.
- `cmd_op` out 3: operation code.
- `cmd_addr` out ADDR_W: target address.
- `cmd_data` out 8: write data.
- `rsp_valid` in 1: one-cycle read-data strobe from the consumer.
- `rsp_data` in 8: read data.

## Operation
Opcode field is `reg_q[3:0]`, taken on a byte with `reg_addr_q==0` while in IDLE:
- 0 NOP
- 1 READ_MEM
- 2 WRITE_MEM
- 3 READ_SEQ
- 4 WRITE_SEQ
- 5 BREAK
- 6 RESET
- 7 UART_TX
- 8–15 illegal: ignored and set `overrun`.

Argument bytes follow; `reg_addr_q` is ignored for them.
- READ_MEM: ADDR_W/8 address bytes, MSB first.
- WRITE_MEM: address bytes, then 1 data byte.
- WRITE_SEQ and UART_TX: 1 data byte.
- READ_SEQ, BREAK, RESET: none.

Address and sequence pointer:
- An internal address pointer holds the last address used.
- READ_SEQ and WRITE_SEQ use pointer+1 and store it back. Wrap-around is modulo 2^ADDR_W.
- READ_MEM and WRITE_MEM load the pointer from the address bytes.

States:
- IDLE: on a command byte, go to ADDR, DATA or ISSUE according to the opcode. NOP stays in IDLE and clears `overrun`.
- ADDR: shift in one byte per update. After the last byte, go to DATA for WRITE_MEM, else to ISSUE.
- DATA: latch `cmd_data`, then go to ISSUE.
- ISSUE: hold `cmd_valid`=1 with stable `cmd_op`/`cmd_addr`/`cmd_data` until `cmd_valid & cmd_ready`. Then go to WAIT for read ops, else to IDLE.
- WAIT: on `rsp_valid`, latch `rsp_data` into `reg_d`, set `resp_valid`, go to IDLE.

Rules and boundary conditions:
- A new command byte clears `resp_valid`.
- `busy` = state ≠ IDLE.
- A `reg_update` during ISSUE or WAIT is dropped, sets `overrun`, and changes no other state.
- `overrun` is sticky until a NOP.
- `rsp_valid` outside WAIT is ignored.

## Timing
- Reset values: all outputs 0; state IDLE; pointer 0.
- Each byte is registered on the `jtck` edge where `reg_update`=1.
- `cmd_valid` rises on the cycle after the final argument byte, or after the command byte for zero-argument ops.
- Handshake completes in the same cycle as `cmd_ready` (zero-wait ready allowed). `busy` falls the next cycle, for non-read ops.
- `reg_d`/`resp_valid` update the cycle after `rsp_valid`.
- `rsp_valid` coincident with `cmd_valid & cmd_ready` is ignored.
- `jrstn` low mid-command aborts it immediately. `cmd_valid` drops asynchronously and no partial command is issued.

## Structure
- Shared package `jtag_debug_pkg`:
  - opcode constants;
  - state encoding;
  - status bit indices.
- One sub-module, `jtag_debug_shiftreg`: MSB-first address assembler with byte counter and last-byte flag.

## Test plan
- Reset, then bytes 0x01, 0x12, 0x34, 0x56, 0x78 with `cmd_ready`=1 → one-cycle `cmd_valid`, op 1, addr 0x12345678; `rsp_valid` with 0xA5 → `reg_d`=0xA5, `reg_addr_d`=3'b010.
- WRITE_MEM to 0xFFFFFFFF with data 0x3C, then WRITE_SEQ with data 0x11 → second command has addr 0x00000000 and data 0x11 (wrap-around).
- UART_TX 0x41 with `cmd_ready` held low for 5 cycles → `cmd_valid` and fields stable for 5 cycles; an extra byte in that window sets `overrun` (`reg_addr_d[2]`=1).
- Illegal opcode 0x0F → no command issued and `overrun`=1; then NOP → `overrun`=0.
- `jrstn` pulsed low after 2 of 4 address bytes → `busy`=0 and `cmd_valid`=0; a following BREAK issues op 5 with addr 0x00000000.
- READ_SEQ with `rsp_valid` arriving in the handshake cycle → `rsp_valid` ignored and `resp_valid` stays 0 until the next `rsp_valid`.
